// File: rtl/gray_step_ctrl.sv
// Gray-coded position stepper: walks a binary position up or down by a
// programmed count, one step every DIV clocks, with a registered Gray copy.
module gray_step_ctrl #(
    parameter int SIZE = 4,
    parameter int DIV  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dir,
    input  logic [SIZE-1:0] len,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic            pause,
    input  logic            abort,
    output logic [SIZE-1:0] bin_out,
    output logic [SIZE-1:0] gray_out,
    output logic            step_valid,
    output logic            busy,
    output logic            done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [SIZE-1:0] steps_left_q, steps_left_d;
    logic            dir_q, dir_d;
    logic [SIZE-1:0] bin_q, bin_d;
    logic [SIZE-1:0] gray_q, gray_d;
    logic            step_valid_q, step_valid_d;
    logic            advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prescaler_q  <= '0;
            steps_left_q <= '0;
            dir_q        <= 1'b0;
            bin_q        <= '0;
            gray_q       <= '0;
            step_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            bin_q        <= bin_d;
            gray_q       <= gray_d;
            step_valid_q <= step_valid_d;
        end
    end

    // Leaving HOLD counts as a normal RUN cycle, so each held cycle costs exactly one clock.
    always_comb begin
        state_d      = state_q;
        prescaler_d  = prescaler_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        bin_d        = bin_q;
        step_valid_d = 1'b0;
        advance      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d = load_val;
                end else if (start) begin
                    if (len != '0) begin
                        dir_d        = dir;
                        steps_left_d = len;
                        prescaler_d  = '0;
                        state_d      = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else begin
                    advance = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                    advance = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (prescaler_q == PW'(DIV - 1)) begin
                prescaler_d  = '0;
                bin_d        = dir_q ? (bin_q - SIZE'(1)) : (bin_q + SIZE'(1));
                step_valid_d = 1'b1;
                steps_left_d = steps_left_q - SIZE'(1);
                if (steps_left_q == SIZE'(1)) begin
                    state_d = DONE;
                end
            end else begin
                prescaler_d = prescaler_q + PW'(1);
            end
        end

        gray_d = bin_d ^ (bin_d >> 1);
    end

    assign bin_out    = bin_q;
    assign gray_out   = gray_q;
    assign step_valid = step_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed bench for gray_step_ctrl: a cycle-by-cycle vector table plus
// hand-written sequences for pause, abort, mid-run reset, zero length and DIV=1.
module tb_gray_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [3:0] len;
    logic       load;
    logic [3:0] load_val;
    logic       pause;
    logic       abort;

    logic [3:0] bin_out, gray_out;
    logic       step_valid, busy, done;
    logic [3:0] bin_out1, gray_out1;
    logic       step_valid1, busy1, done1;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       dir;
        logic [3:0] len;
        logic       load;
        logic [3:0] load_val;
        logic       pause;
        logic       abort;
        logic [3:0] e_bin;
        logic [3:0] e_gray;
        logic       e_sv;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[24];

    gray_step_ctrl #(.SIZE(4), .DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .len(len),
        .load(load), .load_val(load_val), .pause(pause), .abort(abort),
        .bin_out(bin_out), .gray_out(gray_out), .step_valid(step_valid),
        .busy(busy), .done(done)
    );

    gray_step_ctrl #(.SIZE(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .len(len),
        .load(load), .load_val(load_val), .pause(pause), .abort(abort),
        .bin_out(bin_out1), .gray_out(gray_out1), .step_valid(step_valid1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        start    = v.start;
        dir      = v.dir;
        len      = v.len;
        load     = v.load;
        load_val = v.load_val;
        pause    = v.pause;
        abort    = v.abort;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rst = 1'b0; start = 1'b0; dir = 1'b0; len = 4'd0;
        load = 1'b0; load_val = 4'd0; pause = 1'b0; abort = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int doneEdge, svCount, doneCount, svWhilePaused, binChanges;
        logic [3:0] finalGray;
        int expBin[4];
        int expSv[4];
        int expBusy[4];
        int expDone[4];

        //            rst start dir len   load lv    pause abort  bin    gray   sv busy done
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 4'd9, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1,  4'd1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 4'd9, 1'b0, 1'b0, 4'd1,  4'd1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2,  4'd3, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2,  4'd3, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3,  4'd2, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3,  4'd2, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4,  4'd6, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4,  4'd6, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5,  4'd7, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5,  4'd7, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1,  4'd1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1,  4'd1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1,  4'd1, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd15, 4'd8, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd15, 4'd8, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd14, 4'd9, 1'b1, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd14, 4'd9, 1'b0, 1'b0, 1'b0};

        clearInputs();
        tick();

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d bin_out", i), int'(bin_out), int'(vecs[i].e_bin));
            checkOutput($sformatf("vec%0d gray_out", i), int'(gray_out), int'(vecs[i].e_gray));
            checkOutput($sformatf("vec%0d step_valid", i), int'(step_valid), int'(vecs[i].e_sv));
            checkOutput($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
            checkOutput($sformatf("vec%0d done", i), int'(done), int'(vecs[i].e_done));
        end

        // Pause for three cycles after the second step of a four-step run.
        doReset();
        start = 1'b1; dir = 1'b0; len = 4'd4;
        tick();
        start = 1'b0;
        doneEdge = -1; svCount = 0; doneCount = 0; svWhilePaused = 0; finalGray = 4'd0;
        for (int e = 1; e <= 20; e++) begin
            pause = (e >= 5 && e <= 7);
            tick();
            if (step_valid) begin
                svCount++;
                if (e >= 5 && e <= 8) svWhilePaused++;
            end
            if (done) begin
                doneCount++;
                if (doneEdge < 0) begin
                    doneEdge  = e;
                    finalGray = gray_out;
                end
            end
        end
        pause = 1'b0;
        checkOutput("pause done edge", doneEdge, 11);
        checkOutput("pause step count", svCount, 4);
        checkOutput("pause steps while held", svWhilePaused, 0);
        checkOutput("pause done count", doneCount, 1);
        checkOutput("pause final gray", int'(finalGray), 6);
        checkOutput("pause final bin", int'(bin_out), 4);
        checkOutput("pause busy after", int'(busy), 0);

        // Abort after two of six steps.
        doReset();
        start = 1'b1; dir = 1'b0; len = 4'd6;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort bin", int'(bin_out), 2);
        checkOutput("abort gray", int'(gray_out), 3);
        doneCount = 0; binChanges = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (done) doneCount++;
            if (bin_out != 4'd2) binChanges++;
        end
        checkOutput("abort no done", doneCount, 0);
        checkOutput("abort bin held", binChanges, 0);

        // Reset in the middle of a run.
        doReset();
        start = 1'b1; dir = 1'b0; len = 4'd5;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 3; e++) tick();
        checkOutput("midrst pre bin", int'(bin_out), 1);
        rst = 1'b1;
        tick();
        checkOutput("midrst bin", int'(bin_out), 0);
        checkOutput("midrst gray", int'(gray_out), 0);
        checkOutput("midrst busy", int'(busy), 0);
        checkOutput("midrst done", int'(done), 0);
        checkOutput("midrst step_valid", int'(step_valid), 0);
        rst = 1'b0;
        doneCount = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (done || step_valid) doneCount++;
        end
        checkOutput("midrst no done or step", doneCount, 0);

        // Zero-length run from a loaded position.
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        checkOutput("len0 done", int'(done), 1);
        checkOutput("len0 busy", int'(busy), 1);
        checkOutput("len0 step_valid", int'(step_valid), 0);
        checkOutput("len0 bin", int'(bin_out), 7);
        tick();
        checkOutput("len0 done after", int'(done), 0);
        checkOutput("len0 busy after", int'(busy), 0);
        checkOutput("len0 bin after", int'(bin_out), 7);
        checkOutput("len0 gray after", int'(gray_out), 4);

        // DIV=1 instance: one step on every clock.
        doReset();
        expBin  = '{1, 2, 3, 3};
        expSv   = '{1, 1, 1, 0};
        expBusy = '{1, 1, 1, 0};
        expDone = '{0, 0, 1, 0};
        start = 1'b1; dir = 1'b0; len = 4'd3;
        tick();
        start = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            checkOutput($sformatf("div1 e%0d bin", e + 1), int'(bin_out1), expBin[e]);
            checkOutput($sformatf("div1 e%0d step_valid", e + 1), int'(step_valid1), expSv[e]);
            checkOutput($sformatf("div1 e%0d busy", e + 1), int'(busy1), expBusy[e]);
            checkOutput($sformatf("div1 e%0d done", e + 1), int'(done1), expDone[e]);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
